// File: rtl/s2p_tile_buffer_if.sv
// Operand stream in, completed im2col tile out, for s2p_tile_buffer.
// master = producer/consumer side, slave = the tile buffer.
interface s2p_tile_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE       = 3,
    parameter int NUM_CH     = 2
);
    localparam int N = TILE * TILE;

    logic [NUM_CH*DATA_WIDTH-1:0]   i_data;
    logic [NUM_CH-1:0]              i_pad_zero;
    logic                           i_valid;
    logic                           o_ready;
    logic                           i_flush;
    logic [NUM_CH*N*DATA_WIDTH-1:0] o_tile;
    logic                           o_valid;
    logic                           i_ready;
    logic                           o_tile_flushed;

    modport master (
        output i_data, i_pad_zero, i_valid, i_flush, i_ready,
        input  o_ready, o_tile, o_valid, o_tile_flushed
    );

    modport slave (
        input  i_data, i_pad_zero, i_valid, i_flush, i_ready,
        output o_ready, o_tile, o_valid, o_tile_flushed
    );
endinterface

// File: rtl/s2p_tile_buffer.sv
// Serial-to-parallel ping-pong tile collector for the GEMM operand path.
// Optional status outputs (tile count, stall sticky) enabled by S2P_STATUS_EN.
module s2p_tile_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE       = 3,
    parameter int NUM_CH     = 2
) (
    input  logic                clk,
    input  logic                rstn,
    s2p_tile_buffer_if.slave    bus
`ifdef S2P_STATUS_EN
    ,
    output logic [15:0]         o_tile_count,
    output logic                o_stall_sticky
`endif
);
    localparam int N  = TILE * TILE;
    localparam int CW = $clog2(N);

    logic [1:0][NUM_CH-1:0][N*DATA_WIDTH-1:0] mem_q;
    logic [1:0]    full_q;
    logic [1:0]    flushed_q;
    logic          wr_q;
    logic          rd_q;
    logic [CW-1:0] cnt_q;
    logic          flush_pend_q;

    logic          ready;
    logic          accept;
    logic          last;
    logic          flush_eff;
    logic          close;
    logic          release_t;
    logic [CW-1:0] slot;

    assign ready     = !full_q[wr_q];
    assign accept    = bus.i_valid && ready;
    assign last      = accept && (cnt_q == CW'(N-1));
    // A flush seen while both banks were full is remembered until the write bank frees up.
    assign flush_eff = (bus.i_flush || flush_pend_q) && ready && ((cnt_q != '0) || accept);
    assign close     = last || flush_eff;
    assign release_t = full_q[rd_q] && bus.i_ready;
    assign slot      = CW'(N-1) - cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q        <= '0;
            full_q       <= '0;
            flushed_q    <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            // Released bank is zeroed here: it is always the next bank to be written.
            if (release_t) begin
                mem_q[rd_q]     <= '0;
                full_q[rd_q]    <= 1'b0;
                flushed_q[rd_q] <= 1'b0;
                rd_q            <= ~rd_q;
            end
            if (accept) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    mem_q[wr_q][c][slot*DATA_WIDTH +: DATA_WIDTH] <=
                        bus.i_pad_zero[c] ? '0 : bus.i_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (close) begin
                full_q[wr_q]    <= 1'b1;
                flushed_q[wr_q] <= !last;
                wr_q            <= ~wr_q;
                cnt_q           <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + CW'(1);
            end
            flush_pend_q <= ready ? 1'b0 : (flush_pend_q || bus.i_flush);
        end
    end

    assign bus.o_ready        = ready;
    assign bus.o_valid        = full_q[rd_q];
    assign bus.o_tile         = mem_q[rd_q];
    assign bus.o_tile_flushed = flushed_q[rd_q];

`ifdef S2P_STATUS_EN
    logic [15:0] tile_count_q;
    logic        stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tile_count_q <= '0;
            stall_q      <= 1'b0;
        end else begin
            if (release_t) tile_count_q <= tile_count_q + 16'd1;
            if (bus.i_valid && !ready) stall_q <= 1'b1;
        end
    end

    assign o_tile_count   = tile_count_q;
    assign o_stall_sticky = stall_q;
`endif
endmodule

// File: tb/tb_s2p_tile_buffer.sv
// Scoreboard bench for s2p_tile_buffer: driver pushes expected tiles, monitor pops on handoff.
module tb_s2p_tile_buffer;
    localparam int DW   = 8;
    localparam int TILE = 3;
    localparam int NCH  = 2;
    localparam int N    = TILE * TILE;
    localparam int TW   = NCH * N * DW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    s2p_tile_buffer_if #(.DATA_WIDTH(DW), .TILE(TILE), .NUM_CH(NCH)) bus ();

`ifdef S2P_STATUS_EN
    logic [15:0] tile_count;
    logic        stall_sticky;
`endif

    s2p_tile_buffer #(.DATA_WIDTH(DW), .TILE(TILE), .NUM_CH(NCH)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .bus   (bus)
`ifdef S2P_STATUS_EN
        ,
        .o_tile_count   (tile_count),
        .o_stall_sticky (stall_sticky)
`endif
    );

    typedef struct {
        logic [TW-1:0] tile;
        logic          fl;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chkw(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push(input logic [TW-1:0] t, input logic fl);
        exp_t e;
        e.tile = t;
        e.fl   = fl;
        q.push_back(e);
    endtask

    // Element k of a tile goes to slot N-1-k; ch1 beats flagged in pad1 are zero.
    function automatic logic [TW-1:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                         input int n, input logic [N-1:0] pad1);
        logic [TW-1:0] t;
        t = '0;
        for (int k = 0; k < n; k++) begin
            t[(N-1-k)*DW +: DW]        = b0 + 8'(k);
            t[N*DW + (N-1-k)*DW +: DW] = pad1[k] ? 8'h00 : b1 + 8'(k);
        end
        return t;
    endfunction

    always @(negedge clk) begin
        if (rstn && bus.o_valid && bus.i_ready) begin
            exp_t e;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_tile: got %h expected none", bus.o_tile);
            end else begin
                e = q.pop_front();
                chkw("tile_data", bus.o_tile, e.tile);
                chk1("tile_flushed", bus.o_tile_flushed, e.fl);
            end
        end
    end

    task automatic beat(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] pad, input logic fl);
        int n;
        n = 0;
        bus.i_data     = {d1, d0};
        bus.i_pad_zero = pad;
        bus.i_flush    = fl;
        bus.i_valid    = 1'b1;
        while (!bus.o_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.o_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_timeout: got o_ready=0 expected 1 within 2000 cycles");
        end
        @(posedge clk); #1;
        bus.i_valid    = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_pad_zero = '0;
    endtask

    task automatic feed(input logic [7:0] b0, input logic [7:0] b1, input int n,
                        input logic [N-1:0] pad1, input logic flush_last);
        for (int k = 0; k < n; k++)
            beat(b0 + 8'(k), b1 + 8'(k), {pad1[k], 1'b0}, flush_last && (k == n-1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d tiles outstanding expected 0", q.size());
        end
    endtask

    initial begin
        bus.i_data     = '0;
        bus.i_pad_zero = '0;
        bus.i_valid    = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_o_valid", bus.o_valid, 1'b0);
        chk1("rst_o_ready", bus.o_ready, 1'b1);
        chkw("rst_o_tile", bus.o_tile, '0);
        chk1("rst_flushed", bus.o_tile_flushed, 1'b0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Basic tile, latency of one edge after the 9th beat
        bus.i_ready = 1'b1;
        push({72'h111213141516171819, 72'h010203040506070809}, 1'b0);
        for (int k = 0; k < 9; k++) begin
            beat(8'(k + 1), 8'(8'h11 + k), 2'b00, 1'b0);
            if (k == 7) chk1("lat_before_last", bus.o_valid, 1'b0);
        end
        chk1("lat_after_last", bus.o_valid, 1'b1);
        chkw("slot8_ch0", TW'(bus.o_tile[71:64]), TW'(8'h01));
        chkw("slot0_ch0", TW'(bus.o_tile[7:0]), TW'(8'h09));
        drain();

        // Backpressure: two tiles buffered, third stalls until the consumer drains
        bus.i_ready = 1'b0;
        push(mk(8'h21, 8'h31, 9, '0), 1'b0);
        push(mk(8'h41, 8'h51, 9, '0), 1'b0);
        push(mk(8'h61, 8'h71, 9, '0), 1'b0);
        feed(8'h21, 8'h31, 9, '0, 1'b0);
        feed(8'h41, 8'h51, 9, '0, 1'b0);
        chk1("both_full_ready", bus.o_ready, 1'b0);
        chk1("both_full_valid", bus.o_valid, 1'b1);
        fork
            feed(8'h61, 8'h71, 9, '0, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1;
                chk1("stall_ready", bus.o_ready, 1'b0);
                bus.i_ready = 1'b1;
            end
        join
        drain();

        // Flush of a partial tile, then a flush with nothing collected
        push({72'hA5A6A7A80000000000, 72'h050607080000000000}, 1'b1);
        feed(8'h05, 8'hA5, 4, '0, 1'b0);
        chk1("pre_flush_valid", bus.o_valid, 1'b0);
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        chk1("flush_valid", bus.o_valid, 1'b1);
        chk1("flush_flag", bus.o_tile_flushed, 1'b1);
        @(posedge clk); #1;
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk1("empty_flush_no_tile", bus.o_valid, 1'b0);
            @(posedge clk); #1;
        end

        // Flush coinciding with the last element closes the tile normally
        push(mk(8'hC1, 8'hD1, 9, '0), 1'b0);
        feed(8'hC1, 8'hD1, 9, '0, 1'b1);
        drain();

        // Channel-1 padding on beats 3 and 7
        push({72'h919200949596009899, 72'h818283848586878889}, 1'b0);
        feed(8'h81, 8'h91, 9, 9'b001000100, 1'b0);
        drain();

        // Reset with one tile pending and a partial tile in progress
        bus.i_ready = 1'b0;
        feed(8'hA1, 8'hB1, 9, '0, 1'b0);
        feed(8'hC1, 8'hD1, 5, '0, 1'b0);
        chk1("pre_rst_valid", bus.o_valid, 1'b1);
        rstn = 1'b0;
        #1;
        chk1("mid_rst_valid", bus.o_valid, 1'b0);
        chk1("mid_rst_ready", bus.o_ready, 1'b1);
        chkw("mid_rst_tile", bus.o_tile, '0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b1;
        push(mk(8'hE1, 8'hF1, 9, '0), 1'b0);
        feed(8'hE1, 8'hF1, 9, '0, 1'b0);
        drain();

`ifdef S2P_STATUS_EN
        rstn = 1'b0;
        #1;
        chkw("rst_tile_count", TW'(tile_count), TW'(16'd0));
        chk1("rst_stall_sticky", stall_sticky, 1'b0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 3; t++) begin
            push(mk(8'(8'h10 * t), 8'(8'h10 * t + 8'h80), 9, '0), 1'b0);
            feed(8'(8'h10 * t), 8'(8'h10 * t + 8'h80), 9, '0, 1'b0);
        end
        drain();
        bus.i_ready = 1'b0;
        feed(8'h01, 8'h02, 9, '0, 1'b0);
        feed(8'h03, 8'h04, 9, '0, 1'b0);
        chk1("no_stall_yet", stall_sticky, 1'b0);
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        chkw("tile_count", TW'(tile_count), TW'(16'd3));
        chk1("stall_sticky", stall_sticky, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/s2p_tile_buffer.md
Name: s2p_tile_buffer

Overview:
- Parametrised serial-to-parallel tile collector that feeds the GEMM array with im2col operand tiles.
- Accepts one element per cycle on each of NUM_CH parallel operand channels (e.g. tensor and weight) under valid/ready.
- Packs TILE*TILE elements per channel into a ping-pong buffer and presents completed tiles with a valid/ready output handshake.
- Supports per-channel zero padding and flushing of a partial tile.

Parameters:
DATA_WIDTH  8  element width in bits
TILE        3  tile edge; N = TILE*TILE elements per channel per tile (N >= 2)
NUM_CH      2  number of parallel operand channels (channel 0 = tensor, channel 1 = weight)

Ports:
clk            input   1                         clock, all logic on rising edge
rstn           input   1                         asynchronous active-low reset
i_data         input   NUM_CH*DATA_WIDTH         channel c element at bits [c*DATA_WIDTH +: DATA_WIDTH]
i_pad_zero     input   NUM_CH                    per-channel: replace this beat's element with 0
i_valid        input   1                         input beat valid
o_ready        output  1                         input beat can be accepted
i_flush        input   1                         close the current partial tile (single-cycle pulse)
o_tile         output  NUM_CH*N*DATA_WIDTH       channel c tile at bits [c*N*DATA_WIDTH +: N*DATA_WIDTH]
o_valid        output  1                         o_tile holds a complete tile
i_ready        input   1                         consumer takes the tile
o_tile_flushed output  1                         presented tile was closed by flush (zero-filled)

Behaviour:
- Reset values: o_valid=0, o_ready=1, o_tile=0, o_tile_flushed=0. Both banks empty, write bank=0, read bank=0, element counter=0.
- Reset mid-fill or mid-presentation discards all data, with no partial output.
- Accept condition: i_valid && o_ready.
- On accept, each channel stores (i_pad_zero[c] ? 0 : i_data[c]). Padding is applied in the same cycle, with no input sync register.
- Ordering: the k-th accepted element of a tile (k = 0..N-1) lands in slot N-1-k, i.e. bits [(N-1-k)*DATA_WIDTH +: DATA_WIDTH] of that channel. The first element occupies the MSB slot, matching the existing shift order.
- Element counter runs 0..N-1 and wraps to 0 when the N-th element is accepted. That bank is then marked full and the write bank toggles.
- Ping-pong:
  - o_ready = 1 while the write bank is empty.
  - o_ready = 0 when both banks are full.
  - Input stalls with no data loss.
- Output:
  - o_valid = 1 while the read bank is full. o_tile and o_tile_flushed are driven directly from the read bank registers.
  - Tile data is stable while o_valid && !i_ready.
  - On o_valid && i_ready, the read bank is marked empty and the read bank toggles.
- Latency: the last element accepted at edge t gives o_valid=1 after edge t, if the read bank was empty.
- Throughput: 1 element/cycle sustained when i_ready is held high; no bubble between tiles.
- Simultaneous release and fill: if at one edge the consumer releases a bank and the filler completes the other bank, both take effect. o_ready stays 1 and o_valid stays 1 with the new tile.
- Flush:
  - When i_flush=1 and counter>0, or an accept also occurs that cycle, slots not yet written are forced to 0.
  - The bank is marked full with o_tile_flushed=1, the counter is reset to 0, and the write bank toggles.
  - Flush with counter=0 and no accept is ignored.
  - Flush coinciding with the N-th element closes the tile normally, with o_tile_flushed=0.
  - Flush while o_ready=0 and no accept is held off: it takes effect on the first cycle the write bank is empty.
- Bank clear: a bank is cleared to zero on becoming the write bank, so unwritten slots are always 0.
- Misuse: i_valid asserted while o_ready=0 is legal; the beat is simply not accepted.

Optional Feature:
- Macro: S2P_STATUS_EN.
- Defined: adds two outputs.
  - o_tile_count (16 bits): reset 0; increments on every o_valid && i_ready; wraps 0xFFFF->0.
  - o_stall_sticky (1 bit): reset 0; set when i_valid && !o_ready; cleared only by reset.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

Test Plan:
- DATA_WIDTH=8, TILE=3, NUM_CH=2, i_ready=1, feed ch0=1..9 and ch1=0x11..0x19 on consecutive cycles -> o_valid=1 exactly one cycle after the 9th beat. ch0 tile slot8..slot0 = 1..9 (o_tile[71:64]=1, [7:0]=9). o_tile_flushed=0.
- i_ready=0, stream 27 beats -> two tiles buffered, o_ready drops after the 18th accept, beats 19..27 stall. Raise i_ready -> tiles emerge in order, then the third tile completes with no data lost.
- Feed 4 beats (values 5,6,7,8), then pulse i_flush -> o_valid next cycle, ch0 slots8..5 = 5,6,7,8, slots4..0 = 0, o_tile_flushed=1. A flush pulse with an empty counter produces no tile.
- i_pad_zero=2'b10 on beats 3 and 7 -> ch1 slots 6 and 2 = 0, ch0 unaffected.
- Assert rstn=0 after 5 beats of a tile and with one full tile pending -> o_valid=0, o_ready=1, o_tile=0. The next 9 beats form a clean tile.
- With S2P_STATUS_EN: complete 3 tile handoffs and drive i_valid once while o_ready=0 -> o_tile_count=3, o_stall_sticky=1.
